// File: rtl/register_file_sb.sv
// register_file_sb: parametrised integer register file with two combinational
// read ports, one write port and a scoreboard of pending-write bits.
// Register 0 is hardwired to zero and is never pending. A flush clears every
// pending bit but leaves register contents untouched. pending_cnt is the
// registered population count of the pending bits.
module register_file_sb #(
  parameter int XLEN   = 32,
  parameter int REGS   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(REGS),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] di3,
  input  logic            we3,
  input  logic            issue,
  input  logic [AW-1:0]   ai,
  input  logic            flush,
  output logic [CW-1:0]   pending_cnt
);

  logic [XLEN-1:0] regs_q [REGS];
  logic [REGS-1:0] pending_q;
  logic [REGS-1:0] pending_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            wr_en;
  logic            iss_en;

  // Writes and issues that target register 0 are dropped here, so entry 0
  // of the storage and of the pending vector stays zero forever.
  assign wr_en  = we3 && (a3 != '0);
  assign iss_en = issue && (ai != '0) && !flush;

  // Next pending vector: a write retires its register, a same-edge issue to
  // that register re-marks it (the newer producer wins), flush clears all.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wr_en) pending_d[a3] = 1'b0;
      if (iss_en) pending_d[ai] = 1'b1;
    end
  end

  // Population count of the next pending vector, registered with it.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < REGS; i++) begin
      cnt_d = cnt_d + CW'(pending_d[i]);
    end
  end

  // Register storage; flush never touches data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[a3] <= di3;
    end
  end

  // Pending bits and their count update on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  // Read port 1: optional write-through, forced to zero while reset is held.
  always_comb begin
    rd1   = '0;
    busy1 = 1'b0;
    if (!reset) begin
      if ((BYPASS != 0) && wr_en && (a3 == a1)) begin
        rd1 = di3;
      end else begin
        rd1   = regs_q[a1];
        busy1 = pending_q[a1];
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2   = '0;
    busy2 = 1'b0;
    if (!reset) begin
      if ((BYPASS != 0) && wr_en && (a3 == a2)) begin
        rd2 = di3;
      end else begin
        rd2   = regs_q[a2];
        busy2 = pending_q[a2];
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb (XLEN=32, REGS=32, BYPASS=1). A behavioural
// model of the architectural registers and pending set is updated on each
// clock edge; a compare process checks every output at each falling edge.
// Directed scenarios add hand-computed literal checks.
module tb_register_file_sb;

  localparam int XLEN = 32;
  localparam int REGS = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   a1, a2, a3, ai;
  logic [XLEN-1:0] rd1, rd2, di3;
  logic            busy1, busy2, we3, issue, flush;
  logic [AW:0]     pending_cnt;

  register_file_sb #(.XLEN(XLEN), .REGS(REGS), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .a3(a3), .di3(di3), .we3(we3), .issue(issue), .ai(ai), .flush(flush),
    .pending_cnt(pending_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [XLEN-1:0] m_regs [REGS] = '{default: '0};
  bit              m_pend [REGS] = '{default: 1'b0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we3 && a3 != 0) m_regs[a3] = di3;
      if (flush) begin
        for (int i = 0; i < REGS; i++) m_pend[i] = 1'b0;
      end else begin
        if (we3 && a3 != 0) m_pend[a3] = 1'b0;
        if (issue && ai != 0) m_pend[ai] = 1'b1;
      end
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (reset) return '0;
    if (we3 && a3 == a && a != 0) return di3;
    if (a == 0) return '0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (reset) return 1'b0;
    if (we3 && a3 == a && a != 0) return 1'b0;
    if (a == 0) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < REGS; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    exp_q.push_back(exp_rd(a1));
    exp_q.push_back(exp_rd(a2));
    check("rd1", rd1, exp_q.pop_front());
    check("rd2", rd2, exp_q.pop_front());
    check("busy1", XLEN'(busy1), XLEN'(exp_busy(a1)));
    check("busy2", XLEN'(busy2), XLEN'(exp_busy(a2)));
    check("pending_cnt", XLEN'(pending_cnt), XLEN'(exp_cnt()));
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    we3 = 1'b0; issue = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    a1 = '0; a2 = '0; a3 = '0; ai = '0; di3 = '0;
    idle();
    repeat (2) tick();

    // Reset held: outputs zero even with a write/issue in flight.
    we3 = 1'b1; a3 = 5'd4; di3 = 32'd77; a1 = 5'd4; a2 = 5'd4;
    issue = 1'b1; ai = 5'd4;
    settle();
    check("reset_rd1", rd1, 32'd0);
    check("reset_busy1", XLEN'(busy1), 32'd0);
    tick();
    idle();
    reset = 1'b0;

    // 1: every address reads zero, nothing pending.
    for (int i = 0; i < REGS; i++) begin
      a1 = AW'(i); a2 = AW'(REGS - 1 - i);
      settle();
    end
    check("t1_cnt", XLEN'(pending_cnt), 32'd0);
    check("t1_rd2", rd2, 32'd0);

    // 2: write 69 to reg1, visible same cycle via bypass and after the edge.
    tick();
    a1 = 5'd1; we3 = 1'b1; a3 = 5'd1; di3 = 32'd69;
    settle();
    check("t2_bypass", rd1, 32'd69);
    tick();
    idle();
    settle();
    check("t2_stored", rd1, 32'd69);

    // 3: register 0 ignores writes and issues.
    tick();
    a1 = 5'd0; we3 = 1'b1; a3 = 5'd0; di3 = 32'hDEADBEEF; issue = 1'b1; ai = 5'd0;
    settle();
    check("t3_rd0", rd1, 32'd0);
    tick();
    idle();
    settle();
    check("t3_busy0", XLEN'(busy1), 32'd0);
    check("t3_cnt", XLEN'(pending_cnt), 32'd0);

    // 4: issue 5 and 7, then retire 5.
    tick();
    issue = 1'b1; ai = 5'd5;
    tick();
    ai = 5'd7;
    tick();
    idle();
    a1 = 5'd5; a2 = 5'd7;
    settle();
    check("t4_busy1", XLEN'(busy1), 32'd1);
    check("t4_busy2", XLEN'(busy2), 32'd1);
    check("t4_cnt2", XLEN'(pending_cnt), 32'd2);
    tick();
    we3 = 1'b1; a3 = 5'd5; di3 = 32'd3;
    tick();
    idle();
    settle();
    check("t4_rd1", rd1, 32'd3);
    check("t4_busy1_clr", XLEN'(busy1), 32'd0);
    check("t4_cnt1", XLEN'(pending_cnt), 32'd1);

    // 5: same-edge issue and write to reg9: data lands, stays pending.
    tick();
    issue = 1'b1; ai = 5'd9; we3 = 1'b1; a3 = 5'd9; di3 = 32'd11; a1 = 5'd9;
    tick();
    idle();
    settle();
    check("t5_rd", rd1, 32'd11);
    check("t5_busy", XLEN'(busy1), 32'd1);
    check("t5_cnt", XLEN'(pending_cnt), 32'd2);

    // 6: pend 3,4,6 then flush with issue 8 and write 3.
    tick();
    issue = 1'b1; ai = 5'd3;
    tick(); ai = 5'd4;
    tick(); ai = 5'd6;
    tick();
    idle();
    settle();
    check("t6_cnt5", XLEN'(pending_cnt), 32'd5);
    tick();
    flush = 1'b1; issue = 1'b1; ai = 5'd8; we3 = 1'b1; a3 = 5'd3; di3 = 32'd42;
    tick();
    idle();
    a1 = 5'd3; a2 = 5'd8;
    settle();
    check("t6_cnt0", XLEN'(pending_cnt), 32'd0);
    check("t6_rd3", rd1, 32'd42);
    check("t6_busy8", XLEN'(busy2), 32'd0);

    // Random traffic, addresses biased low to create collisions.
    for (int n = 0; n < 600; n++) begin
      tick();
      a1    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a2    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      a3    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ai    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      di3   = $urandom;
      we3   = ($urandom_range(0, 99) < 50);
      issue = ($urandom_range(0, 99) < 45);
      flush = ($urandom_range(0, 99) < 4);
    end

    // Reset mid-write: everything reads zero at once.
    tick();
    we3 = 1'b1; a3 = 5'd9; di3 = 32'h1234; a1 = 5'd9; a2 = 5'd3;
    #1 reset = 1'b1;
    #1;
    check("rst_rd1", rd1, 32'd0);
    check("rst_rd2", rd2, 32'd0);
    check("rst_cnt", XLEN'(pending_cnt), 32'd0);
    idle();
    tick();
    reset = 1'b0;
    for (int i = 0; i < REGS; i++) begin
      a1 = AW'(i); a2 = AW'(i);
      settle();
    end
    check("post_rst_rd", rd1, 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
